// File: rtl/game_pkg.sv
// Shared obstacle-field definitions for the obstacle generator and the collision checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: field sizes, play-area bounds, packed obstacle slice positions,
// off-screen sentinel values, game-mode encodings and the collision FSM state type.
package game_pkg;

   localparam int NUM_OBSTACLES = 10;
   localparam int SCREEN_WIDTH  = 640;
   localparam int UPPER_BOUND   = 20;
   localparam int LOWER_BOUND   = 440;

   // A slot parked at these coordinates is empty (left edge beyond the screen).
   localparam logic [9:0] OFFSCREEN_X = 10'd700;
   localparam logic [8:0] OFFSCREEN_Y = 9'd500;

   // obstacle_x slot = {left[19:10], right[9:0]}
   localparam int X_LEFT_HI  = 19;
   localparam int X_LEFT_LO  = 10;
   localparam int X_RIGHT_HI = 9;
   localparam int X_RIGHT_LO = 0;

   // obstacle_y slot = {top[17:9], bottom[8:0]}
   localparam int Y_TOP_HI = 17;
   localparam int Y_TOP_LO = 9;
   localparam int Y_BOT_HI = 8;
   localparam int Y_BOT_LO = 0;

   localparam logic [1:0] GM_CLEAR = 2'b00;
   localparam logic [1:0] GM_RUN   = 2'b01;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } coll_state_t;

   function automatic logic [19:0] pack_x(input logic [9:0] left, input logic [9:0] right);
      return {left, right};
   endfunction

   function automatic logic [17:0] pack_y(input logic [8:0] top, input logic [8:0] bottom);
      return {top, bottom};
   endfunction

endpackage

// File: rtl/rect_overlap.sv
// Strict axis-aligned overlap test of two rectangles; shared edges do not count.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: a_* / b_* - left, right, top, bottom edges of rectangles A and B (W bits each);
//        overlap   - 1 when the interiors intersect.
module rect_overlap #(
   parameter int W = 11
) (
   input  logic [W-1:0] a_left,
   input  logic [W-1:0] a_right,
   input  logic [W-1:0] a_top,
   input  logic [W-1:0] a_bottom,
   input  logic [W-1:0] b_left,
   input  logic [W-1:0] b_right,
   input  logic [W-1:0] b_top,
   input  logic [W-1:0] b_bottom,
   output logic         overlap
);

   assign overlap = (a_left < b_right) && (b_left < a_right) &&
                    (a_top  < b_bottom) && (b_top < a_bottom);

endmodule

// File: rtl/obstacle_collision.sv
// Per-frame collision check of the player against a snapshot of all obstacle slots and the play-area borders.
// Latency: done pulses NUM_OBSTACLES+1 clocks after the accepted frame_tick edge (one slot scanned per clock).
// Backpressure: none; a frame_tick arriving while busy is dropped and flagged in sticky tick_overrun.
//
// Ports: clk, rst_n (async active-low); frame_tick starts a scan when gamemode=01;
//        obstacle_x/obstacle_y packed slot rectangles; player_x/player_y player top-left corner;
//        busy, done, collision, border_hit, hit_index, hit_count, tick_overrun - scan status and results.
module obstacle_collision #(
   parameter int NUM_OBSTACLES = game_pkg::NUM_OBSTACLES,
   parameter int SCREEN_WIDTH  = game_pkg::SCREEN_WIDTH,
   parameter int UPPER_BOUND   = game_pkg::UPPER_BOUND,
   parameter int LOWER_BOUND   = game_pkg::LOWER_BOUND,
   parameter int PLAYER_W      = 20,
   parameter int PLAYER_H      = 20
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           frame_tick,
   input  logic [1:0]                     gamemode,
   input  logic [NUM_OBSTACLES-1:0][19:0] obstacle_x,
   input  logic [NUM_OBSTACLES-1:0][17:0] obstacle_y,
   input  logic [9:0]                     player_x,
   input  logic [8:0]                     player_y,
   output logic                           busy,
   output logic                           done,
   output logic                           collision,
   output logic                           border_hit,
   output logic [3:0]                     hit_index,
   output logic [7:0]                     hit_count,
   output logic                           tick_overrun
);

   import game_pkg::*;

   localparam logic [9:0]  SCREEN_W_C = 10'(SCREEN_WIDTH);
   localparam logic [8:0]  UPPER_C    = 9'(UPPER_BOUND);
   localparam logic [9:0]  LOWER_C    = 10'(LOWER_BOUND);
   localparam logic [10:0] PW_C       = 11'(PLAYER_W);
   localparam logic [9:0]  PH_C       = 10'(PLAYER_H);
   localparam logic [3:0]  LAST_IDX   = 4'(NUM_OBSTACLES - 1);
   localparam logic [3:0]  NO_HIT     = 4'hF;

   coll_state_t                    state;
   logic [NUM_OBSTACLES-1:0][19:0] snap_x;
   logic [NUM_OBSTACLES-1:0][17:0] snap_y;
   logic [9:0]                     snap_px;
   logic [8:0]                     snap_py;
   logic [3:0]                     idx;
   logic                           acc_hit;
   logic [3:0]                     acc_idx;

   // Player extents from the snapshot; widened so the sums never wrap.
   logic [10:0] p_right;
   logic [9:0]  p_bottom;
   logic        border;

   assign p_right  = {1'b0, snap_px} + PW_C;
   assign p_bottom = {1'b0, snap_py} + PH_C;
   assign border   = (snap_py < UPPER_C) || (p_bottom > LOWER_C);

   // Single comparator shared across all slots, steered by the scan index.
   logic [19:0] cur_x;
   logic [17:0] cur_y;
   logic [9:0]  cur_left;
   logic [9:0]  cur_right;
   logic [8:0]  cur_top;
   logic [8:0]  cur_bot;
   logic        overlap;
   logic        slot_hit;

   assign cur_x     = snap_x[idx];
   assign cur_y     = snap_y[idx];
   assign cur_left  = cur_x[X_LEFT_HI:X_LEFT_LO];
   assign cur_right = cur_x[X_RIGHT_HI:X_RIGHT_LO];
   assign cur_top   = cur_y[Y_TOP_HI:Y_TOP_LO];
   assign cur_bot   = cur_y[Y_BOT_HI:Y_BOT_LO];

   rect_overlap #(.W(11)) u_overlap (
      .a_left   ({1'b0, snap_px}),
      .a_right  (p_right),
      .a_top    ({2'b00, snap_py}),
      .a_bottom ({1'b0, p_bottom}),
      .b_left   ({1'b0, cur_left}),
      .b_right  ({1'b0, cur_right}),
      .b_top    ({2'b00, cur_top}),
      .b_bottom ({2'b00, cur_bot}),
      .overlap  (overlap)
   );

   // Parked slots (left edge off-screen) never count as hits.
   assign slot_hit = overlap && (cur_left < SCREEN_W_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         snap_x       <= '0;
         snap_y       <= '0;
         snap_px      <= '0;
         snap_py      <= '0;
         idx          <= '0;
         acc_hit      <= 1'b0;
         acc_idx      <= NO_HIT;
         busy         <= 1'b0;
         done         <= 1'b0;
         collision    <= 1'b0;
         border_hit   <= 1'b0;
         hit_index    <= NO_HIT;
         hit_count    <= '0;
         tick_overrun <= 1'b0;
      end else begin
         done <= 1'b0;

         // busy covers SCAN and REPORT, so a tick during either is an overrun.
         if (frame_tick && busy) begin
            tick_overrun <= 1'b1;
         end

         if (gamemode == GM_CLEAR) begin
            // Clear mode wins over everything: drop any scan, wipe results, keep the overrun flag.
            state      <= IDLE;
            busy       <= 1'b0;
            collision  <= 1'b0;
            border_hit <= 1'b0;
            hit_index  <= NO_HIT;
            hit_count  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (frame_tick && (gamemode == GM_RUN)) begin
                     snap_x  <= obstacle_x;
                     snap_y  <= obstacle_y;
                     snap_px <= player_x;
                     snap_py <= player_y;
                     idx     <= '0;
                     acc_hit <= 1'b0;
                     acc_idx <= NO_HIT;
                     busy    <= 1'b1;
                     state   <= SCAN;
                  end
               end
               SCAN: begin
                  if (slot_hit) begin
                     acc_hit <= 1'b1;
                     if (acc_idx == NO_HIT) begin
                        acc_idx <= idx;
                     end
                  end
                  if (idx == LAST_IDX) begin
                     state <= REPORT;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
               REPORT: begin
                  collision  <= acc_hit | border;
                  border_hit <= border;
                  hit_index  <= acc_idx;
                  if ((acc_hit | border) && (hit_count != 8'hFF)) begin
                     hit_count <= hit_count + 8'd1;
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_obstacle_collision.sv
// Self-checking bench for obstacle_collision: scoreboard of expected scan results.
// Expected results are computed from the inputs at tick time and pushed; each done pulse pops one.
`timescale 1ns/1ps
module tb_obstacle_collision;
   import game_pkg::*;

   localparam int N  = NUM_OBSTACLES;
   localparam int PW = 20;
   localparam int PH = 20;

   typedef struct packed {
      logic       collision;
      logic       border_hit;
      logic [3:0] hit_index;
      logic [7:0] hit_count;
   } res_t;

   logic                 clk        = 1'b0;
   logic                 rst_n      = 1'b0;
   logic                 frame_tick = 1'b0;
   logic [1:0]           gamemode   = 2'b00;
   logic [N-1:0][19:0]   obstacle_x;
   logic [N-1:0][17:0]   obstacle_y;
   logic [9:0]           player_x   = 10'd0;
   logic [8:0]           player_y   = 9'd0;
   logic                 busy;
   logic                 done;
   logic                 collision;
   logic                 border_hit;
   logic [3:0]           hit_index;
   logic [7:0]           hit_count;
   logic                 tick_overrun;

   int   n_cmp = 0;
   int   n_err = 0;
   res_t sb[$];
   int   exp_count = 0;
   bit   busy_trace [0:40];
   bit   busy_e0;
   res_t rst_obs;
   bit   rst_busy;
   bit   rst_ovr;

   obstacle_collision dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick   (frame_tick),
      .gamemode     (gamemode),
      .obstacle_x   (obstacle_x),
      .obstacle_y   (obstacle_y),
      .player_x     (player_x),
      .player_y     (player_y),
      .busy         (busy),
      .done         (done),
      .collision    (collision),
      .border_hit   (border_hit),
      .hit_index    (hit_index),
      .hit_count    (hit_count),
      .tick_overrun (tick_overrun)
   );

   always #5 clk = ~clk;

   function automatic res_t observed();
      return res_t'({collision, border_hit, hit_index, hit_count});
   endfunction

   task automatic clear_obstacles();
      for (int i = 0; i < N; i++) begin
         obstacle_x[i] = pack_x(OFFSCREEN_X, OFFSCREEN_X);
         obstacle_y[i] = pack_y(OFFSCREEN_Y, OFFSCREEN_Y);
      end
   endtask

   task automatic set_slot(input int i, input int l, input int r, input int t, input int b);
      obstacle_x[i] = pack_x(10'(l), 10'(r));
      obstacle_y[i] = pack_y(9'(t), 9'(b));
   endtask

   // Reference model: lowest overlapping on-screen slot, border check, saturating counter.
   task automatic push_expected();
      int   first;
      int   px;
      int   py;
      int   l, r, t, b;
      bit   brd;
      bit   coll;
      first = 15;
      px    = int'(player_x);
      py    = int'(player_y);
      for (int i = N - 1; i >= 0; i--) begin
         l = int'(obstacle_x[i][19:10]);
         r = int'(obstacle_x[i][9:0]);
         t = int'(obstacle_y[i][17:9]);
         b = int'(obstacle_y[i][8:0]);
         if (l < SCREEN_WIDTH && px < r && l < px + PW && py < b && t < py + PH) first = i;
      end
      brd  = (py < UPPER_BOUND) || (py + PH > LOWER_BOUND);
      coll = (first != 15) || brd;
      if (coll && exp_count < 255) exp_count++;
      sb.push_back(res_t'({coll, brd, 4'(first), 8'(exp_count)}));
   endtask

   // Issue one tick, optionally perform an action before edge act_at, watch up to 30 edges.
   // act: 1 gamemode->00, 2 gamemode->10, 3 scramble inputs, 4 async reset pulse, 5 extra tick.
   task automatic run_tick(input int act_at, input int act, input bit stop_on_done,
                           output int lat, output int ndone, output res_t got);
      lat   = -1;
      ndone = 0;
      got   = '0;
      for (int k = 0; k <= 40; k++) busy_trace[k] = 1'b0;
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      busy_e0    = busy;
      for (int k = 1; k <= 30; k++) begin
         if (k == act_at) begin
            case (act)
               1: gamemode = 2'b00;
               2: gamemode = 2'b10;
               3: begin
                  player_x = 10'd300;
                  player_y = 9'd300;
                  for (int i = 0; i < N; i++) set_slot(i, 0, 639, 0, 400);
               end
               4: begin
                  rst_n = 1'b0;
                  #1;
                  rst_busy = busy;
                  rst_ovr  = tick_overrun;
                  rst_obs  = observed();
                  rst_n    = 1'b1;
               end
               5: frame_tick = 1'b1;
               default: ;
            endcase
         end
         @(posedge clk); #1;
         frame_tick    = 1'b0;
         busy_trace[k] = busy;
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat = k;
               got = observed();
            end
            if (stop_on_done) break;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (done !== 1'b0)         begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (collision !== 1'b0)    begin n_err++; $display("FAIL reset_collision got=%b exp=0", collision); end
      n_cmp++; if (border_hit !== 1'b0)   begin n_err++; $display("FAIL reset_border got=%b exp=0", border_hit); end
      n_cmp++; if (hit_index !== 4'hF)    begin n_err++; $display("FAIL reset_hit_index got=%h exp=f", hit_index); end
      n_cmp++; if (hit_count !== 8'd0)    begin n_err++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count); end
      n_cmp++; if (tick_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%b exp=0", tick_overrun); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_no_obstacles();
      int lat, nd; res_t got, e;
      clear_obstacles(); player_x = 10'd100; player_y = 9'd200; gamemode = GM_RUN;
      @(posedge clk); #1;
      push_expected();
      run_tick(0, 0, 0, lat, nd, got);
      e = sb.pop_front();
      n_cmp++; if (busy_e0 !== 1'b1)       begin n_err++; $display("FAIL empty_busy_e0 got=%b exp=1", busy_e0); end
      n_cmp++; if (lat != 11)              begin n_err++; $display("FAIL empty_latency got=%0d exp=11", lat); end
      n_cmp++; if (nd != 1)                begin n_err++; $display("FAIL empty_done_count got=%0d exp=1", nd); end
      n_cmp++; if (got !== e)              begin n_err++; $display("FAIL empty_result got=%h exp=%h", got, e); end
      n_cmp++; if (busy_trace[10] !== 1'b1) begin n_err++; $display("FAIL empty_busy_report got=%b exp=1", busy_trace[10]); end
      n_cmp++; if (busy_trace[11] !== 1'b0) begin n_err++; $display("FAIL empty_busy_after got=%b exp=0", busy_trace[11]); end
      n_cmp++; if (tick_overrun !== 1'b0)  begin n_err++; $display("FAIL empty_overrun got=%b exp=0", tick_overrun); end
   endtask

   task automatic test_priority();
      int lat, nd; res_t got, e;
      clear_obstacles(); player_x = 10'd100; player_y = 9'd200;
      set_slot(3, 90, 130, 190, 260);
      set_slot(7, 110, 150, 210, 230);
      push_expected();
      run_tick(0, 0, 0, lat, nd, got);
      e = sb.pop_front();
      n_cmp++; if (lat != 11)  begin n_err++; $display("FAIL prio_latency got=%0d exp=11", lat); end
      n_cmp++; if (got !== e)  begin n_err++; $display("FAIL prio_result got=%h exp=%h", got, e); end
   endtask

   task automatic test_edge_touch();
      int lat, nd; res_t got, e;
      for (int c = 0; c < 3; c++) begin
         clear_obstacles(); player_y = 9'd200;
         if (c == 2) begin
            player_x = 10'd100; set_slot(0, 90, 130, 220, 260);
         end else begin
            player_x = (c == 0) ? 10'd100 : 10'd101; set_slot(0, 120, 160, 190, 260);
         end
         push_expected();
         run_tick(0, 0, 0, lat, nd, got);
         e = sb.pop_front();
         n_cmp++; if (got !== e) begin n_err++; $display("FAIL edge_case%0d got=%h exp=%h", c, got, e); end
      end
   endtask

   task automatic test_border();
      int lat, nd; res_t got, e;
      int ys [4] = '{425, 19, 20, 420};
      clear_obstacles(); player_x = 10'd100;
      foreach (ys[j]) begin
         player_y = 9'(ys[j]);
         push_expected();
         run_tick(0, 0, 0, lat, nd, got);
         e = sb.pop_front();
         n_cmp++; if (got !== e) begin n_err++; $display("FAIL border_y%0d got=%h exp=%h", ys[j], got, e); end
      end
   endtask

   task automatic test_snapshot();
      int lat, nd; res_t got, e;
      clear_obstacles(); player_x = 10'd100; player_y = 9'd200;
      push_expected();
      run_tick(2, 3, 0, lat, nd, got);
      e = sb.pop_front();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL snapshot_result got=%h exp=%h", got, e); end
      clear_obstacles(); player_x = 10'd100; player_y = 9'd200;
   endtask

   task automatic test_overrun();
      int lat, nd; res_t got, e;
      set_slot(5, 95, 105, 195, 205);
      push_expected();
      run_tick(5, 5, 0, lat, nd, got);
      e = sb.pop_front();
      n_cmp++; if (tick_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_flag got=%b exp=1", tick_overrun); end
      n_cmp++; if (lat != 11)             begin n_err++; $display("FAIL overrun_latency got=%0d exp=11", lat); end
      n_cmp++; if (nd != 1)               begin n_err++; $display("FAIL overrun_done_count got=%0d exp=1", nd); end
      n_cmp++; if (got !== e)             begin n_err++; $display("FAIL overrun_result got=%h exp=%h", got, e); end
   endtask

   task automatic test_freeze();
      int lat, nd; res_t got, e;
      clear_obstacles(); set_slot(9, 50, 110, 150, 210);
      push_expected();
      run_tick(3, 2, 0, lat, nd, got);
      e = sb.pop_front();
      n_cmp++; if (lat != 11) begin n_err++; $display("FAIL freeze_latency got=%0d exp=11", lat); end
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL freeze_result got=%h exp=%h", got, e); end
      // Still frozen: a new tick must be ignored and results must hold.
      player_y = 9'd0;
      run_tick(0, 0, 0, lat, nd, got);
      n_cmp++; if (nd != 0)                 begin n_err++; $display("FAIL frozen_done_count got=%0d exp=0", nd); end
      n_cmp++; if (busy_trace[1] !== 1'b0)  begin n_err++; $display("FAIL frozen_busy got=%b exp=0", busy_trace[1]); end
      n_cmp++; if (observed() !== e)        begin n_err++; $display("FAIL frozen_hold got=%h exp=%h", observed(), e); end
      gamemode = GM_RUN; player_y = 9'd200;
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, nd; res_t got1, got2, e;
      clear_obstacles(); set_slot(2, 100, 140, 100, 210);
      push_expected();
      run_tick(0, 0, 1, lat1, nd, got1);
      clear_obstacles(); set_slot(6, 80, 101, 205, 300);
      push_expected();
      run_tick(0, 0, 1, lat2, nd, got2);
      n_cmp++; if (lat1 != 11) begin n_err++; $display("FAIL b2b_latency1 got=%0d exp=11", lat1); end
      n_cmp++; if (lat2 != 11) begin n_err++; $display("FAIL b2b_latency2 got=%0d exp=11", lat2); end
      e = sb.pop_front();
      n_cmp++; if (got1 !== e) begin n_err++; $display("FAIL b2b_result1 got=%h exp=%h", got1, e); end
      e = sb.pop_front();
      n_cmp++; if (got2 !== e) begin n_err++; $display("FAIL b2b_result2 got=%h exp=%h", got2, e); end
   endtask

   task automatic test_abort();
      int lat, nd; res_t got;
      set_slot(0, 90, 130, 190, 260);
      run_tick(4, 1, 0, lat, nd, got);
      exp_count = 0;
      n_cmp++; if (busy_trace[3] !== 1'b1) begin n_err++; $display("FAIL abort_busy_before got=%b exp=1", busy_trace[3]); end
      n_cmp++; if (busy_trace[4] !== 1'b0) begin n_err++; $display("FAIL abort_busy_after got=%b exp=0", busy_trace[4]); end
      n_cmp++; if (nd != 0)                begin n_err++; $display("FAIL abort_done_count got=%0d exp=0", nd); end
      n_cmp++; if (observed() !== res_t'({1'b0, 1'b0, 4'hF, 8'd0}))
         begin n_err++; $display("FAIL abort_cleared got=%h exp=%h", observed(), res_t'({1'b0, 1'b0, 4'hF, 8'd0})); end
      n_cmp++; if (tick_overrun !== 1'b1)  begin n_err++; $display("FAIL abort_overrun_kept got=%b exp=1", tick_overrun); end
      gamemode = GM_RUN;
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      int lat, nd; res_t got, e;
      clear_obstacles(); player_x = 10'd100; player_y = 9'd0;
      for (int s = 0; s < 257; s++) begin
         push_expected();
         run_tick(0, 0, 1, lat, nd, got);
         e = sb.pop_front();
         n_cmp++; if (got !== e) begin n_err++; $display("FAIL sat_scan%0d got=%h exp=%h", s, got, e); end
      end
      n_cmp++; if (hit_count !== 8'd255) begin n_err++; $display("FAIL sat_final got=%0d exp=255", hit_count); end
      player_y = 9'd200;
   endtask

   task automatic test_async_reset();
      int lat, nd; res_t got;
      run_tick(5, 4, 0, lat, nd, got);
      exp_count = 0;
      n_cmp++; if (rst_busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got=%b exp=0", rst_busy); end
      n_cmp++; if (rst_ovr !== 1'b0)  begin n_err++; $display("FAIL arst_overrun got=%b exp=0", rst_ovr); end
      n_cmp++; if (rst_obs !== res_t'({1'b0, 1'b0, 4'hF, 8'd0}))
         begin n_err++; $display("FAIL arst_outputs got=%h exp=%h", rst_obs, res_t'({1'b0, 1'b0, 4'hF, 8'd0})); end
      n_cmp++; if (nd != 0)                begin n_err++; $display("FAIL arst_done_count got=%0d exp=0", nd); end
      n_cmp++; if (busy_trace[6] !== 1'b0) begin n_err++; $display("FAIL arst_busy_after got=%b exp=0", busy_trace[6]); end
   endtask

   initial begin
      clear_obstacles();
      test_reset();
      test_no_obstacles();
      test_priority();
      test_edge_touch();
      test_border();
      test_snapshot();
      test_overrun();
      test_freeze();
      test_back_to_back();
      test_abort();
      test_saturation();
      test_async_reset();
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/obstacle_collision.md
Name: obstacle_collision

Overview:
- Consumer of the obstacle list produced by the obstacle generator. It also checks the player rectangle against the play-area borders.
- On each frame tick it snapshots all obstacle rectangles and the player position. It then scans one obstacle per clock against the player rectangle.
- It reports a per-frame collision result to the game-control FSM.

Parameters:
- NUM_OBSTACLES, 10, number of obstacle slots scanned.
- SCREEN_WIDTH, 640, x at or beyond which an obstacle is treated as off-screen.
- UPPER_BOUND, 20, top edge of the play area in pixels.
- LOWER_BOUND, 440, bottom edge of the play area in pixels.
- PLAYER_W, 20, player width in pixels.
- PLAYER_H, 20, player height in pixels.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- frame_tick, in, 1, one-cycle pulse per video frame that starts a scan.
- gamemode, in, 2, 00 = idle/clear, 01 = running, 10/11 = frozen.
- obstacle_x, in, [NUM_OBSTACLES-1:0][19:0], per slot {left[19:10], right[9:0]}.
- obstacle_y, in, [NUM_OBSTACLES-1:0][17:0], per slot {top[17:9], bottom[8:0]}.
- player_x, in, 10, player left edge.
- player_y, in, 9, player top edge.
- busy, out, 1, high while a scan is in progress.
- done, out, 1, one-cycle pulse when a scan's results are published.
- collision, out, 1, result of the last completed scan (obstacle hit OR border hit).
- border_hit, out, 1, player outside the play area in the last completed scan.
- hit_index, out, 4, lowest obstacle index hit in the last scan; 4'hF if none.
- hit_count, out, 8, saturating count of scans with collision=1.
- tick_overrun, out, 1, sticky; a frame_tick arrived while busy.

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE. Outputs: busy=0, done=0, collision=0, border_hit=0, hit_index=4'hF, hit_count=0, tick_overrun=0. All snapshot registers are cleared.
- FSM states: IDLE, SCAN, REPORT.
- IDLE -> SCAN on a clock edge where frame_tick=1 and gamemode=01.
  - On that edge: latch all obstacle_x/y, player_x and player_y into snapshot registers; idx=0; clear accumulators (acc_hit=0, acc_idx=F).
  - Compute border flag from the snapshot: player_y < UPPER_BOUND, or player_y+PLAYER_H > LOWER_BOUND. Use 10-bit add.
- SCAN: each edge evaluates slot idx.
  - Hit when all of the following hold, with strict inequalities (touching edges are not a hit):
    - left < SCREEN_WIDTH (excludes the off-screen sentinel {700,700}/{500,500});
    - player_x < right;
    - left < player_x+PLAYER_W (11-bit);
    - player_y < bottom;
    - top < player_y+PLAYER_H (10-bit).
  - On a hit with acc_idx==F: acc_idx=idx. On any hit: acc_hit=1.
  - idx increments each edge; at idx==NUM_OBSTACLES-1, go to REPORT.
- REPORT, for exactly one cycle:
  - collision = acc_hit | border; border_hit = border; hit_index = acc_idx; done=1.
  - hit_count increments if collision, saturating at 255.
  - Next state IDLE.
- Latency:
  - Tick sampled at edge E0.
  - done is visible after edge E(NUM_OBSTACLES+1) (11 clocks at default).
  - busy is high from E0 through the REPORT cycle inclusive.
  - Back-to-back ticks are accepted from the first IDLE cycle after REPORT.
- frame_tick while busy: ignored; tick_overrun set to 1 (cleared only by reset).
- gamemode handling:
  - gamemode=00, any state: synchronous abort to IDLE; no done. collision, border_hit and hit_count are cleared; hit_index=F. tick_overrun is kept.
  - gamemode=10/11: new ticks are ignored and outputs hold. A scan already started completes and publishes normally, since it runs from the snapshot.
- Input changes during SCAN have no effect (snapshot only).
- Async reset mid-scan: immediate return to reset values; no done.

Decomposition:
- game_pkg holds:
  - NUM_OBSTACLES, SCREEN_WIDTH, UPPER_BOUND, LOWER_BOUND;
  - the off-screen sentinel values (X 700, Y 500);
  - field-slice constants for the packed {left,right} and {top,bottom} formats;
  - typedef enum for the FSM state (IDLE/SCAN/REPORT).
  - The obstacle generator and this block share the package.
- Sub-module rect_overlap: purely combinational strict AABB overlap of two rectangles, parameterised by coordinate width. Instantiated once, muxed by idx.

Test Plan:
- Reset, then gamemode=01, all slots at sentinel, player (100,200), one tick -> done after 11 clocks; collision=0, border_hit=0, hit_index=F, hit_count=0.
- Slot 3 = x{90,130} y{190,260}, slot 7 overlapping the player too, player (100,200) -> hit_index=3, collision=1, hit_count=1.
- Edge touch: slot 0 x{120,160}, player_x=100 (right=120) -> no hit. Move the player to 101 -> hit, hit_index=0.
- Player_y=425 (bottom 445 > 440), no obstacles -> border_hit=1, collision=1, hit_index=F.
- Second tick 5 clocks after the first -> tick_overrun=1; the first scan still reports at 11 clocks; only one done pulse.
- Mid-scan gamemode->00 at clock 4 -> busy=0 next cycle, no done, hit_count=0, hit_index=F. Separately, a gamemode->10 mid-scan -> the scan completes and done pulses.
